// File: rtl/approx_mult_div_8x4.sv
// -----------------------------------------------------------------------------
// approx_mult_div_8x4
//
// Sequential restoring divider. It is the inverse of the 4x4 multiplier family:
// given a product-domain value R and operand B it recovers A = R / B, plus the
// remainder. The core produces one quotient bit per clock, MSB first, and holds
// one division in flight. Both sides use valid/ready handshakes.
//
// Parameters
//   DW  dividend / quotient width (default 8)
//   VW  divisor / remainder width (default 4), VW <= DW, DW >= 2
//
// Ports
//   clk        in   1    clock, rising edge
//   rst        in   1    asynchronous active-high reset
//   in_valid   in   1    dividend/divisor valid
//   in_ready   out  1    high only in IDLE
//   dividend   in   DW   unsigned dividend
//   divisor    in   VW   unsigned divisor
//   out_valid  out  1    quotient/remainder/dz valid (high in DONE)
//   out_ready  in   1    downstream accepts the result
//   quotient   out  DW   unsigned quotient (all ones on divide-by-zero)
//   remainder  out  VW   unsigned remainder, < divisor when divisor != 0
//   dz         out  1    divide-by-zero flag, qualified by out_valid
//
// Latency from the accept cycle to out_valid: DW+1 cycles for a full run,
// 1 cycle for divide-by-zero.
//
// Optional feature (compile-time macro DIV_EARLY_EXIT_EN):
//   When defined, an accepted operation with divisor != 0 and
//   dividend < divisor skips the iterations and finishes in 1 cycle with
//   quotient = 0, remainder = dividend. Results are the same either way.
// -----------------------------------------------------------------------------
module approx_mult_div_8x4 #(
    parameter int DW = 8,
    parameter int VW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          dz
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;

    // Iteration registers. The partial remainder is always < divisor after a
    // step, so only its low VW bits need storage; the (VW+1)-bit trial value
    // is rebuilt each cycle from it plus the next dividend bit.
    logic [VW-1:0] pr;
    logic [DW-1:0] sr;
    logic [VW-1:0] dvs;
    logic [CW-1:0] cnt;

    logic          accept;
    logic          div_zero;
    logic          early_exit;

    logic [VW:0]   shifted;
    logic          take;
    logic [VW-1:0] trial_lo;
    logic [VW-1:0] pr_next;
    logic [DW-1:0] sr_next;

    assign accept   = in_valid && in_ready;
    assign div_zero = (divisor == '0);

`ifdef DIV_EARLY_EXIT_EN
    assign early_exit = !div_zero && (dividend < DW'(divisor));
`else
    assign early_exit = 1'b0;
`endif

    // One restoring step. When the trial subtraction is non-negative its
    // result is < divisor, so computing it modulo 2^VW loses nothing.
    assign shifted  = {pr, sr[DW-1]};
    assign take     = (shifted >= {1'b0, dvs});
    assign trial_lo = shifted[VW-1:0] - dvs;
    assign pr_next  = take ? trial_lo : shifted[VW-1:0];
    assign sr_next  = {sr[DW-2:0], take};

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs, decoded purely from state except for
    // the accept decision.
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (div_zero || early_exit) begin
                        state_next = DONE;
                    end else begin
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                if (cnt == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath and result registers. Results change only on completion, so
    // they stay put in DONE under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pr        <= '0;
            sr        <= '0;
            dvs       <= '0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
            dz        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (div_zero) begin
                            quotient  <= '1;
                            remainder <= '0;
                            dz        <= 1'b1;
                        end else if (early_exit) begin
                            quotient  <= '0;
                            remainder <= dividend[VW-1:0];
                            dz        <= 1'b0;
                        end else begin
                            pr  <= '0;
                            sr  <= dividend;
                            dvs <= divisor;
                            cnt <= CW'(DW - 1);
                        end
                    end
                end
                RUN: begin
                    pr  <= pr_next;
                    sr  <= sr_next;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        quotient  <= sr_next;
                        remainder <= pr_next;
                        dz        <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_approx_mult_div_8x4.sv
// -----------------------------------------------------------------------------
// tb_approx_mult_div_8x4
//
// Self-checking bench for approx_mult_div_8x4. Expected results come from
// plain integer division in the bench; latency expectations come from the
// documented cycle counts. Directed cases, randomized operations with random
// backpressure, a mid-run reset and an exhaustive dividend/divisor sweep.
// -----------------------------------------------------------------------------
module tb_approx_mult_div_8x4;

`ifdef DIV_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       dz;

    int checks = 0;
    int errors = 0;
    int cur_a  = 0;
    int cur_b  = 0;

    approx_mult_div_8x4 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .dz        (dz)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (op %0d / %0d)", tag, got, exp, cur_a, cur_b);
        end
    endtask

    // Reference model: plain arithmetic on the operands.
    task automatic model(input int a, input int b,
                         output int q, output int r, output int z, output int lat);
        if (b == 0) begin
            q = 255; r = 0; z = 1; lat = 1;
        end else begin
            q = a / b; r = a % b; z = 0;
            lat = (EARLY && a < b) ? 1 : 9;
        end
    endtask

    // Issue one operation (inputs driven on negedges), measure latency, hold
    // backpressure for bp cycles while poking in_valid, then drain.
    task automatic run_op(input int a, input int b, input int bp, input bit chk_lat);
        int q, r, z, lat, seen;
        model(a, b, q, r, z, lat);
        cur_a = a;
        cur_b = b;
        @(negedge clk);
        check("idle_in_ready", int'(in_ready), 1);
        in_valid = 1'b1;
        dividend = 8'(a);
        divisor  = 4'(b);
        @(negedge clk);
        in_valid = 1'b0;
        dividend = 8'($urandom);
        divisor  = 4'($urandom);
        seen = 1;
        while (!out_valid && seen < 40) begin
            @(negedge clk);
            seen++;
        end
        if (chk_lat) check("latency", seen, lat);
        check("out_valid", int'(out_valid), 1);
        check("quotient", int'(quotient), q);
        check("remainder", int'(remainder), r);
        check("dz", int'(dz), z);
        for (int i = 0; i < bp; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            dividend = 8'($urandom);
            divisor  = 4'($urandom);
            @(negedge clk);
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_quotient", int'(quotient), q);
            check("bp_remainder", int'(remainder), r);
            check("bp_dz", int'(dz), z);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("drain_out_valid", int'(out_valid), 0);
        check("drain_in_ready", int'(in_ready), 1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_quotient", int'(quotient), 0);
        check("rst_remainder", int'(remainder), 0);
        check("rst_dz", int'(dz), 0);
        rst = 1'b0;

        // Directed cases.
        run_op(225, 15, 0, 1'b1);
        run_op(200, 7, 0, 1'b1);
        run_op(255, 1, 0, 1'b1);
        run_op(37, 0, 0, 1'b1);
        run_op(3, 9, 0, 1'b1);
        run_op(0, 5, 0, 1'b1);
        run_op(100, 13, 5, 1'b1);
        run_op(201, 11, 0, 1'b1);

        // Reset in the middle of a run, with a non-zero prior result held.
        run_op(225, 15, 0, 1'b1);
        cur_a = 200;
        cur_b = 7;
        @(negedge clk);
        in_valid = 1'b1;
        dividend = 8'd200;
        divisor  = 4'd7;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("run_in_ready", int'(in_ready), 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_in_ready", int'(in_ready), 1);
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_quotient", int'(quotient), 0);
        check("midrst_remainder", int'(remainder), 0);
        check("midrst_dz", int'(dz), 0);
        @(negedge clk);
        rst = 1'b0;
        run_op(77, 6, 0, 1'b1);

        // Randomized operations with random backpressure.
        for (int i = 0; i < 200; i++) begin
            run_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 3)), 1'b1);
        end

        // Exhaustive sweep over every dividend and non-zero divisor.
        for (int b = 1; b < 16; b++) begin
            for (int a = 0; a < 256; a++) begin
                run_op(a, b, 0, 1'b1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
